// File: rtl/lb_responder.sv
// Local-bus responder: sixteen RW config registers, status/ID words and a
// readout window onto an external circular buffer with a release handshake.
module lb_responder #(
    parameter int unsigned buf_aw  = 10,
    parameter logic [31:0] id_word = 32'h4c42_5250
) (
    input  logic              lb_clk,
    input  logic              lb_rst_n,
    input  logic [14:0]       lb_addr,
    input  logic [31:0]       lb_data,
    input  logic              lb_write,
    input  logic              lb_read,
    output logic [31:0]       lb_out,
    output logic [511:0]      cfg_flat,
    output logic [buf_aw-1:0] buf_rd_addr,
    input  logic [15:0]       buf_rd_data,
    input  logic              buf_avail,
    output logic              buf_release
);

    localparam int unsigned NCFG = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 16;

    localparam logic [14:0] ADDR_STATUS = 15'd16;
    localparam logic [14:0] ADDR_ID     = 15'd17;
    localparam logic [14:0] ADDR_LAST   = 15'(16384 + (1 << buf_aw) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        DRAIN = 2'd2
    } buf_state_t;

    logic [DW-1:0] cfg [NCFG];
    buf_state_t    state;
    logic [CW-1:0] rel_cnt;

    logic          cfg_hit;
    logic          buf_hit;
    logic          last_hit;
    logic          release_go;
    logic [DW-1:0] status_word;
    logic [DW-1:0] rd_mux_c;

    logic          s1_valid;
    logic          s1_buf;
    logic [DW-1:0] s1_data;

    // Address decode and the non-buffer read mux, sampled by stage 1.
    always_comb begin
        cfg_hit     = (lb_addr[14:4] == 11'd0);
        buf_hit     = lb_addr[14] && ((lb_addr[13:0] >> buf_aw) == 14'd0);
        last_hit    = (lb_addr == ADDR_LAST);
        release_go  = lb_read && last_hit && (state == READY);
        status_word = {rel_cnt, 13'd0, buf_avail, state};
        rd_mux_c    = '0;
        if (cfg_hit) begin
            rd_mux_c = cfg[lb_addr[3:0]];
        end else if (lb_addr == ADDR_STATUS) begin
            rd_mux_c = status_word;
        end else if (lb_addr == ADDR_ID) begin
            rd_mux_c = id_word;
        end
    end

    assign buf_rd_addr = lb_addr[buf_aw-1:0];

    // Config registers; a same-edge read already captured the old value.
    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            for (int i = 0; i < NCFG; i++) begin
                cfg[i] <= '0;
            end
        end else if (lb_write && cfg_hit) begin
            cfg[lb_addr[3:0]] <= lb_data;
        end
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_flat
        assign cfg_flat[DW*g +: DW] = cfg[g];
    end

    // Stage 1: buffer RAM is addressed this cycle, data arrives for stage 2.
    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            s1_valid <= 1'b0;
            s1_buf   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= lb_read;
            s1_buf   <= lb_read && buf_hit;
            if (lb_read) begin
                s1_data <= rd_mux_c;
            end
        end
    end

    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            lb_out <= '0;
        end else if (s1_valid) begin
            lb_out <= s1_buf ? {{(DW-16){buf_rd_data[15]}}, buf_rd_data} : s1_data;
        end
    end

    // Buffer ownership FSM; only the last-word read in READY hands it back.
    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            state       <= IDLE;
            buf_release <= 1'b0;
            rel_cnt     <= '0;
        end else begin
            buf_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (buf_avail) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (release_go) begin
                        state       <= DRAIN;
                        buf_release <= 1'b1;
                        rel_cnt     <= rel_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (!buf_avail) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
